// File: rtl/table_pkg.sv
// Shared definitions for the configuration table and its serial loader.
package table_pkg;

    localparam int TBL_DEPTH = 32;
    localparam int TBL_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP_ADDR,
        DUMP_CAP,
        DUMP_SHIFT
    } state_t;

endpackage

// File: rtl/table_if.sv
// Write/read port of a table_symbol: the loader drives it, the table answers.
interface table_if import table_pkg::*; #(
    parameter int DEPTH = TBL_DEPTH,
    parameter int WIDTH = TBL_WIDTH
);
    localparam int AW = $clog2(DEPTH);

    logic             tbl_we;
    logic [AW-1:0]    tbl_addr;
    logic [WIDTH-1:0] tbl_din;
    logic [WIDTH-1:0] tbl_dout;

    modport master (output tbl_we, tbl_addr, tbl_din, input tbl_dout);
    modport slave  (input tbl_we, tbl_addr, tbl_din, output tbl_dout);
endinterface

// File: rtl/table_serdes.sv
// WIDTH-bit shift register with bit counter: serial-in while sipo=1, parallel-in
// then serial-out (MSB first, zero fill) otherwise.
module table_serdes #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sipo,
    input  logic             shift,
    input  logic             load,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             last_bit
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            q   <= pdin;
            cnt <= '0;
        end else if (shift) begin
            q   <= {q[WIDTH-2:0], sipo & sin};
            cnt <= last_bit ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/table_symbol.sv
// DEPTH x WIDTH table: synchronous write, one-cycle registered read.
module table_symbol import table_pkg::*; #(
    parameter int DEPTH = TBL_DEPTH,
    parameter int WIDTH = TBL_WIDTH
) (
    input logic    clk,
    table_if.slave tbl
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (tbl.tbl_we)
            mem[tbl.tbl_addr] <= tbl.tbl_din;
        tbl.tbl_dout <= mem[tbl.tbl_addr];
    end
endmodule

// File: rtl/table_loader.sv
// Serial configuration sequencer for a table_symbol: bit-serial LOAD into the
// table and bit-serial DUMP back out, both MSB first. All outputs registered.
module table_loader import table_pkg::*; #(
    parameter int DEPTH = TBL_DEPTH,
    parameter int WIDTH = TBL_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start_load,
    input  logic    start_dump,
    input  logic    sin,
    input  logic    sin_valid,
    output logic    sout,
    output logic    sout_valid,
    output logic    busy,
    output logic    done,
    table_if.master tbl
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state, state_n;
    logic [AW-1:0]    word_cnt, word_n, addr_n;
    logic [WIDTH-1:0] din_n, sh_q;
    logic             we_n, done_n, sd_clr, sd_shift, sd_load, last_bit;

    table_serdes #(.WIDTH(WIDTH)) u_serdes (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sd_clr),
        .sipo     (state == LOAD),
        .shift    (sd_shift),
        .load     (sd_load),
        .sin      (sin),
        .pdin     (tbl.tbl_dout),
        .q        (sh_q),
        .last_bit (last_bit)
    );

    // The serdes MSB is itself a flop, so sout stays a registered output.
    assign sout = sh_q[WIDTH-1];

    always_comb begin
        state_n  = state;
        word_n   = word_cnt;
        addr_n   = tbl.tbl_addr;
        din_n    = tbl.tbl_din;
        we_n     = 1'b0;
        done_n   = 1'b0;
        sd_clr   = 1'b0;
        sd_shift = 1'b0;
        sd_load  = 1'b0;
        case (state)
            IDLE: begin
                sd_clr = 1'b1;
                word_n = '0;
                if (start_load) begin
                    state_n = LOAD;
                end else if (start_dump) begin
                    state_n = DUMP_ADDR;
                    addr_n  = '0;
                end
            end
            LOAD: begin
                // Stay one extra cycle so busy covers the final write.
                if (tbl.tbl_we && tbl.tbl_addr == LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (sin_valid) begin
                    sd_shift = 1'b1;
                    if (last_bit) begin
                        we_n   = 1'b1;
                        din_n  = {sh_q[WIDTH-2:0], sin};
                        addr_n = word_cnt;
                        if (word_cnt != LAST)
                            word_n = word_cnt + 1'b1;
                    end
                end
            end
            DUMP_ADDR: state_n = DUMP_CAP;
            DUMP_CAP: begin
                sd_load = 1'b1;
                state_n = DUMP_SHIFT;
            end
            DUMP_SHIFT: begin
                sd_shift = 1'b1;
                if (last_bit) begin
                    if (word_cnt == LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        word_n  = word_cnt + 1'b1;
                        addr_n  = word_cnt + 1'b1;
                        state_n = DUMP_ADDR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            word_cnt     <= '0;
            tbl.tbl_we   <= 1'b0;
            tbl.tbl_addr <= '0;
            tbl.tbl_din  <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            sout_valid   <= 1'b0;
        end else begin
            state        <= state_n;
            word_cnt     <= word_n;
            tbl.tbl_we   <= we_n;
            tbl.tbl_addr <= addr_n;
            tbl.tbl_din  <= din_n;
            done         <= done_n;
            busy         <= (state_n != IDLE);
            sout_valid   <= (state_n == DUMP_SHIFT);
        end
    end
endmodule

// File: tb/tb_table_loader.sv
// Directed + randomized bench for table_loader: DEPTH=4/WIDTH=8 and DEPTH=5/WIDTH=4.
module tb_table_loader;
    logic       clk = 1'b0;
    logic       rst_n, sin, sin_valid;
    logic [1:0] start_load, start_dump;
    logic       a_sout, a_sv, a_busy, a_done;
    logic       b_sout, b_sv, b_busy, b_done;

    table_if #(.DEPTH(4), .WIDTH(8)) ifa ();
    table_if #(.DEPTH(5), .WIDTH(4)) ifb ();

    table_loader #(.DEPTH(4), .WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_load(start_load[0]), .start_dump(start_dump[0]),
        .sin(sin), .sin_valid(sin_valid), .sout(a_sout), .sout_valid(a_sv),
        .busy(a_busy), .done(a_done), .tbl(ifa));
    table_symbol #(.DEPTH(4), .WIDTH(8)) mem_a (.clk(clk), .tbl(ifa));

    table_loader #(.DEPTH(5), .WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_load(start_load[1]), .start_dump(start_dump[1]),
        .sin(sin), .sin_valid(sin_valid), .sout(b_sout), .sout_valid(b_sv),
        .busy(b_busy), .done(b_done), .tbl(ifb));
    table_symbol #(.DEPTH(5), .WIDTH(4)) mem_b (.clk(clk), .tbl(ifb));

    always #5 clk = ~clk;

    int          sel = 0;
    logic        o_sout, o_sv, o_busy, o_done, o_we;
    logic [31:0] o_addr, o_din;

    assign o_sout = (sel == 1) ? b_sout : a_sout;
    assign o_sv   = (sel == 1) ? b_sv : a_sv;
    assign o_busy = (sel == 1) ? b_busy : a_busy;
    assign o_done = (sel == 1) ? b_done : a_done;
    assign o_we   = (sel == 1) ? ifb.tbl_we : ifa.tbl_we;
    assign o_addr = (sel == 1) ? 32'(ifb.tbl_addr) : 32'(ifa.tbl_addr);
    assign o_din  = (sel == 1) ? 32'(ifb.tbl_din) : 32'(ifa.tbl_din);

    int          npass = 0, ntot = 0;
    int          max_addr_b = 0;
    logic [31:0] exp_tbl [2][5];
    logic [31:0] ld_words [5];
    bit          exp_we;
    int          we_idx, sv_seen, done_early;

    function automatic int dep(input int s);
        return (s == 1) ? 5 : 4;
    endfunction

    function automatic int wid(input int s);
        return (s == 1) ? 4 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (sel == 1 && o_addr > 32'(max_addr_b)) max_addr_b = int'(o_addr);
    endtask

    // Any write must be the one implied by the bit just delivered.
    task automatic obs_load(input int s);
        if (exp_we || o_we) begin
            check("load_we", 32'(o_we), 32'(exp_we));
            if (exp_we) begin
                check("load_addr", o_addr, we_idx);
                check("load_din", o_din, ld_words[we_idx]);
                exp_tbl[s][we_idx] = ld_words[we_idx];
                we_idx++;
            end
        end
        if (o_sv) sv_seen++;
        if (o_done) done_early++;
    endtask

    task automatic do_load(input int s, input int stop_bits, input bit gappy, input bit both);
        int depth = dep(s);
        int width = wid(s);
        int nbits = (stop_bits < 0) ? depth * width : stop_bits;
        sel = s; we_idx = 0; sv_seen = 0; done_early = 0; exp_we = 1'b0;
        start_load[s] = 1'b1;
        start_dump[s] = both;
        step();
        start_load[s] = 1'b0;
        start_dump[s] = 1'b0;
        check("load_busy_rise", 32'(o_busy), 1);
        for (int k = 0; k < nbits; k++) begin
            while (gappy && $urandom_range(1) == 1) begin
                sin_valid = 1'b0;
                sin = 1'($urandom_range(1));
                exp_we = 1'b0;
                step(); obs_load(s);
            end
            sin_valid = 1'b1;
            sin = ld_words[k / width][width - 1 - k % width];
            exp_we = (k % width == width - 1);
            start_dump[s] = (k == width + 2);
            step(); obs_load(s);
            start_dump[s] = 1'b0;
        end
        sin_valid = 1'b0;
        exp_we = 1'b0;
        if (stop_bits < 0) begin
            step();
            check("load_done", 32'(o_done), 1);
            check("load_busy_fall", 32'(o_busy), 0);
            check("load_words", we_idx, depth);
        end else begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            check("abort_busy", 32'(o_busy), 0);
            check("abort_we", 32'(o_we), 0);
            check("abort_words", we_idx, stop_bits / width);
            for (int i = 0; i < 4; i++) begin
                step(); obs_load(s);
            end
        end
        check("load_no_sout", sv_seen, 0);
        check("load_no_early_done", done_early, 0);
    endtask

    task automatic do_dump(input int s);
        int depth = dep(s);
        int width = wid(s);
        int nb = 0, rel = 1, w, j;
        bit fin = 1'b0;
        sel = s;
        start_dump[s] = 1'b1;
        step();
        start_dump[s] = 1'b0;
        check("dump_busy_rise", 32'(o_busy), 1);
        while (!fin && rel <= depth * (width + 2) + 8) begin
            if (o_sv) begin
                w = nb / width;
                j = nb % width;
                if (w < depth) begin
                    check("dump_bit", 32'(o_sout), 32'(exp_tbl[s][w][width - 1 - j]));
                    check("dump_slot", rel, 1 + w * (width + 2) + 2 + j);
                end
                nb++;
            end
            if (o_done) fin = 1'b1;
            else begin
                step();
                rel++;
            end
        end
        check("dump_nbits", nb, depth * width);
        check("dump_done_cycle", rel, depth * (width + 2) + 1);
        check("dump_busy_fall", 32'(o_busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        start_load = '0; start_dump = '0;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 5; a++) exp_tbl[s][a] = '0;
        step(); step();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            check("rst_busy", 32'(o_busy), 0);
            check("rst_done", 32'(o_done), 0);
            check("rst_sout_valid", 32'(o_sv), 0);
            check("rst_sout", 32'(o_sout), 0);
            check("rst_we", 32'(o_we), 0);
            check("rst_addr", o_addr, 0);
            check("rst_din", o_din, 0);
        end
        rst_n = 1'b1;
        step();

        ld_words = '{32'hA5, 32'h3C, 32'hFF, 32'h01, 32'h00};
        do_load(0, -1, 1'b0, 1'b0);
        do_dump(0);
        do_load(0, -1, 1'b1, 1'b0);
        do_dump(0);

        for (int a = 0; a < 4; a++) ld_words[a] = 32'($urandom_range(255));
        do_load(0, -1, 1'b1, 1'b1);
        do_dump(0);

        // Reset after 5 bits of word 2: words 0-1 new, 2-3 keep earlier data.
        for (int a = 0; a < 4; a++) ld_words[a] = 32'($urandom_range(255));
        do_load(0, 2 * 8 + 5, 1'b0, 1'b0);
        do_dump(0);

        for (int a = 0; a < 5; a++) ld_words[a] = 32'($urandom_range(15));
        max_addr_b = 0;
        do_load(1, -1, 1'b0, 1'b0);
        do_dump(1);
        for (int a = 0; a < 5; a++) ld_words[a] = 32'($urandom_range(15));
        do_load(1, -1, 1'b1, 1'b0);
        do_dump(1);
        check("b_max_addr", max_addr_b, 4);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/table_loader.md
# table_loader

Sequencer that owns the write/read port of a `table_symbol` instance (`DEPTH` x `WIDTH`, synchronous write, one-cycle registered read). It fills the table from a bit-serial configuration stream (LOAD) and reads it back as a bit-serial stream (DUMP) for verification. It sits between the chip-level serial config pins and the table, driving the table's `we`/`addr`/`din` and consuming its `dout`.

## Interface
- `DEPTH`, 32, number of table words; any value >= 2, not necessarily a power of two.
- `WIDTH`, 32, bits per word; >= 2.
- `AW`, localparam `$clog2(DEPTH)`, table address width.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start_load` input 1: request LOAD; sampled only in IDLE.
- `start_dump` input 1: request DUMP; sampled only in IDLE.
- `sin` input 1: serial config data, MSB of each word first.
- `sin_valid` input 1: `sin` carries a bit this cycle.
- `sout` output 1: serial readback data, MSB first.
- `sout_valid` output 1: `sout` carries a bit this cycle.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle pulse when a LOAD or DUMP finishes.
- `tbl_we` output 1: table write enable.
- `tbl_addr` output AW: table address.
- `tbl_din` output WIDTH: table write data.
- `tbl_dout` input WIDTH: table read data, valid the cycle after `tbl_addr` is presented.

## Operation
- Reset: state IDLE; `sout`, `sout_valid`, `busy`, `done`, `tbl_we` are 0; `tbl_addr` and `tbl_din` are 0. Word and bit counters are 0 and the shift register is cleared.
- States are IDLE, LOAD, DUMP_ADDR, DUMP_CAP, DUMP_SHIFT.
- IDLE: `start_load` moves to LOAD. Otherwise `start_dump` moves to DUMP_ADDR. If both are high, LOAD wins. Both counters are cleared on entry.
- LOAD:
  - Each cycle with `sin_valid`=1 shifts `sin` into the LSB of the shift register and increments the bit counter.
  - The last bit of a word is the cycle in which `sin_valid`=1 and the bit counter equals WIDTH-1. On that cycle the block registers: `tbl_we`=1, `tbl_din`={shift[WIDTH-2:0], sin}, `tbl_addr`=word counter. The bit counter is then cleared and the word counter incremented.
  - `tbl_we` is high for exactly one cycle per word.
  - Bits may arrive back-to-back. Reception of word n+1 overlaps the write of word n without loss.
  - Gaps in `sin_valid` stall reception and hold the partial word.
  - After the write of word DEPTH-1, the next cycle is IDLE with `done`=1. The word counter compares against DEPTH-1 and never wraps through unused addresses.
- DUMP_ADDR: `tbl_addr`=word counter, `tbl_we`=0. Lasts one cycle, then DUMP_CAP.
- DUMP_CAP: `tbl_dout` is valid. It is loaded into the shift register at the end of the cycle. Next state is DUMP_SHIFT.
- DUMP_SHIFT:
  - `sout_valid`=1 and `sout`=shift MSB for WIDTH consecutive cycles. There is no backpressure.
  - After bit WIDTH-1, the next state is DUMP_ADDR for the next word. If the word just sent was DEPTH-1, the next state is IDLE with `done`=1.
- Ignored inputs: `sin_valid` outside LOAD; `start_*` while `busy`=1.
- Reset mid-operation: the next cycle is IDLE and the partial word is discarded. Words already written stay in the table. No `tbl_we` is issued on or after the reset cycle.

## Timing
- `busy` rises the cycle after the start request is sampled. It falls in the same cycle `done` pulses.
- LOAD: a word's `tbl_we` is asserted one cycle after its last `sin` bit.
- LOAD: `done` pulses one cycle after the final `tbl_we`.
- DUMP: each word takes WIDTH+2 cycles, giving DEPTH*(WIDTH+2) cycles from `busy` rising to the final `sout_valid`.
- DUMP: the first `sout_valid` occurs three cycles after the start request is sampled. `done` pulses the cycle after the final bit.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Structure
- Shared package `table_pkg` holds:
  - the state enum (IDLE, LOAD, DUMP_ADDR, DUMP_CAP, DUMP_SHIFT);
  - the default DEPTH/WIDTH localparams used by `table_symbol` and `table_loader`.
- One sub-module is natural: `table_serdes`, a WIDTH-bit shift register with bit counter. It provides serial-in parallel-out for LOAD and parallel-in serial-out for DUMP, selected by a mode input, and raises a `last_bit` flag.
- The parent instantiates `table_symbol` and connects it to `table_loader`. The bench does the same.

## Test plan
- DEPTH=4, WIDTH=8, back-to-back load of 0xA5, 0x3C, 0xFF, 0x01:
  - `tbl_we` pulses at addresses 0..3 with those values;
  - `done` pulses one cycle after the address-3 write.
- Following DUMP:
  - `sout` yields bit pattern 10100101 00111100 11111111 00000001 MSB first;
  - 2-cycle gaps between words;
  - `done` pulses after 40 cycles of activity.
- LOAD with random `sin_valid` gaps (about 50% duty): table contents are identical to the back-to-back case, with no spurious `tbl_we`.
- `start_load` and `start_dump` high together in IDLE: LOAD is entered. A `start_dump` pulse during LOAD is ignored, with no `sout_valid`.
- `rst_n`=0 after 5 bits of word 2 in LOAD:
  - next cycle IDLE, with `busy`=0 and `tbl_we`=0;
  - words 0–1 are retained, confirmed by a subsequent DUMP.
- DEPTH=5 (not a power of two), WIDTH=4:
  - addresses 0..4 are written and read back;
  - the word counter never reaches address 5.
